// File: rtl/pdm_pkg.sv
// pdm_pkg: shared defaults and helpers for the multi-channel PDM block.
// Holds default WIDTH/CHANNELS and the channel-select width function.
package pdm_pkg;

  localparam int PDM_WIDTH    = 5;
  localparam int PDM_CHANNELS = 4;

  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pdm_multi_channel_if.sv
// pdm_multi_channel_if: shared level-write port.
// master drives wr_en/wr_chan/wr_data, slave (the PDM block) samples them.
interface pdm_multi_channel_if #(
  parameter int WIDTH = 5,
  parameter int CH_W  = 2
);

  logic             wr_en;
  logic [CH_W-1:0]  wr_chan;
  logic [WIDTH-1:0] wr_data;

  modport master (output wr_en, wr_chan, wr_data);
  modport slave  (input  wr_en, wr_chan, wr_data);

endinterface

// File: rtl/pdm_channel.sv
// pdm_channel: one sigma-delta PDM lane with shadow/active level regs.
// In: wr_hit, wr_data, commit, frame_zero. Out: pdm, pending, active.
module pdm_channel #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_hit,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             commit,
  input  logic             frame_zero,
  output logic             pdm,
  output logic             pending,
  output logic [WIDTH-1:0] active
);

  logic [WIDTH-1:0] shadow;
  logic [WIDTH-1:0] acc;
  logic [WIDTH:0]   sum;

  // acc restarts each frame, so a frame holds exactly `active` ones
  always_comb begin
    sum = (frame_zero ? '0 : {1'b0, acc}) + {1'b0, active};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow  <= '0;
      active  <= '0;
      acc     <= '0;
      pending <= 1'b0;
      pdm     <= 1'b0;
    end else begin
      acc <= sum[WIDTH-1:0];
      pdm <= sum[WIDTH];
      if (commit && pending) begin
        active  <= shadow;
        pending <= 1'b0;
      end
      // a same-cycle write lands after the commit took the old shadow
      if (wr_hit) begin
        shadow  <= wr_data;
        pending <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/pdm_multi_channel.sv
// pdm_multi_channel: CHANNELS PDM outputs, levels committed at frame end.
// Ports: clk, reset, wr (write if), pdm_out, pending, frame_start;
// with PDM_READBACK_EN also rd_chan/rd_data (registered active readback).
module pdm_multi_channel
  import pdm_pkg::*;
#(
  parameter  int WIDTH    = PDM_WIDTH,
  parameter  int CHANNELS = PDM_CHANNELS,
  localparam int CH_W     = ch_w(CHANNELS)
) (
  input  logic                clk,
  input  logic                reset,
  pdm_multi_channel_if.slave  wr,
`ifdef PDM_READBACK_EN
  input  logic [CH_W-1:0]     rd_chan,
  output logic [WIDTH-1:0]    rd_data,
`endif
  output logic [CHANNELS-1:0] pdm_out,
  output logic [CHANNELS-1:0] pending,
  output logic                frame_start
);

  localparam logic [WIDTH-1:0] LAST = '1;

  logic [WIDTH-1:0] frame_cnt;
  logic             frame_zero;
  logic             commit;
  logic [WIDTH-1:0] active [CHANNELS];

  assign frame_zero = (frame_cnt == '0);
  assign commit     = (frame_cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt   <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_cnt   <= frame_cnt + 1'b1;
      frame_start <= frame_zero;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic wr_hit;
    // out-of-range selects match no lane and are dropped
    assign wr_hit = wr.wr_en && (wr.wr_chan == CH_W'(g));

    pdm_channel #(.WIDTH(WIDTH)) u_ch (
      .clk       (clk),
      .reset     (reset),
      .wr_hit    (wr_hit),
      .wr_data   (wr.wr_data),
      .commit    (commit),
      .frame_zero(frame_zero),
      .pdm       (pdm_out[g]),
      .pending   (pending[g]),
      .active    (active[g])
    );
  end

`ifdef PDM_READBACK_EN
  logic [WIDTH-1:0] rd_next;

  always_comb begin
    rd_next = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (rd_chan == CH_W'(i)) rd_next = active[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) rd_data <= '0;
    else       rd_data <= rd_next;
  end
`endif

endmodule
